// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter and its testbench.
// Holds the burst FSM encoding, the default burst length and the beat counter width.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int DEFAULT_MAX_BURST = 16;
  localparam int BEAT_CNT_W        = 8;

  // Width of a requester index; a one-bit index is kept even when N is 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: picks the first requester strictly after the last owner,
// scanning upward with wrap-around, so the last owner itself is considered last.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_owner,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_valid
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave it unassigned and infer a latch.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!o_valid && i_req[(int'(i_last_owner) + i) % N_REQ]) begin
        o_pick[(int'(i_last_owner) + i) % N_REQ] = 1'b1;
        o_valid                                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-mode round-robin arbiter that funnels N requesters into one FIFO write port.
// Beats are acked combinationally and written to the FIFO one cycle later.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic                   i_clk,
  input  logic                   i_rst_l,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]       o_ack,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_wr_dv,
  output logic [WIDTH-1:0]       o_wr_data,
  input  logic                   i_af_flag,
  output logic                   o_busy
);

  localparam int                    IDX_W     = idx_width(N_REQ);
  localparam logic [BEAT_CNT_W-1:0] MAX_BEATS = BEAT_CNT_W'(MAX_BURST);

  state_e                state_q, state_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]      last_owner_q, last_owner_d;
  logic                  wr_dv_q, wr_dv_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;

  logic [N_REQ-1:0]      pick;
  logic                  pick_valid;
  logic [IDX_W-1:0]      grant_idx;
  logic [WIDTH-1:0]      grant_data;
  logic                  owner_req;
  logic [BEAT_CNT_W-1:0] beat_cnt_inc;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req        (i_req),
    .i_last_owner (last_owner_q),
    .o_pick       (pick),
    .o_valid      (pick_valid)
  );

  // The grant register is one-hot, so a priority-free scan yields its index and data slice.
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        grant_idx  = IDX_W'(k);
        grant_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign owner_req    = |(grant_q & i_req);
  assign beat_cnt_inc = beat_cnt_q + BEAT_CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    wr_dv_d      = 1'b0;
    wr_data_d    = wr_data_q;
    o_ack        = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_BURST;
          grant_d    = pick;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        // Almost-full freezes the burst entirely, including the request-drop exit.
        if (!i_af_flag) begin
          if (owner_req) begin
            o_ack      = grant_q;
            wr_dv_d    = 1'b1;
            wr_data_d  = grant_data;
            beat_cnt_d = beat_cnt_inc;
          end
          if (!owner_req || beat_cnt_inc == MAX_BEATS) begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            last_owner_d = grant_idx;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the statements appear in.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      beat_cnt_q   <= '0;
      last_owner_q <= IDX_W'(N_REQ - 1);
      wr_dv_q      <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
      wr_dv_q      <= wr_dv_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_wr_dv   = wr_dv_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a vector table, directed multi-cycle
// sequences, and randomized traffic into a FIFO model checked against a reference model.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int MB     = DEFAULT_MAX_BURST;
  localparam int DEPTH  = 32;
  localparam int AF_LVL = 2;

  logic             i_clk = 1'b0;
  logic             i_rst_l;
  logic [N-1:0]     i_req;
  logic [N*W-1:0]   i_data;
  logic [N-1:0]     o_ack;
  logic [N-1:0]     o_grant;
  logic             o_wr_dv;
  logic [W-1:0]     o_wr_data;
  logic             i_af_flag;
  logic             o_busy;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .WIDTH     (W),
    .MAX_BURST (MB)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_l   (i_rst_l),
    .i_req     (i_req),
    .i_data    (i_data),
    .o_ack     (o_ack),
    .o_grant   (o_grant),
    .o_wr_dv   (o_wr_dv),
    .o_wr_data (o_wr_data),
    .i_af_flag (i_af_flag),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner is -1 when idle; pending write is the beat acked last cycle.
  int           m_owner;
  int           m_last;
  int           m_beats;
  logic         m_dv;
  logic [W-1:0] m_data;
  logic [N-1:0] m_ack;
  int           seq [N];
  int           fifo_cnt;
  logic         fifo_mode;
  logic         pop_en;
  logic         s_dv;

  typedef struct {
    logic [N-1:0] req;
    logic         af;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic         busy;
    logic         dv;
    logic [W-1:0] data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic drive_data();
    for (int k = 0; k < N; k++) i_data[k*W +: W] = W'((k << 6) | (seq[k] & 63));
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = N - 1;
    m_beats   = 0;
    m_dv      = 1'b0;
    m_data    = '0;
    fifo_cnt  = 0;
    fifo_mode = 1'b0;
    pop_en    = 1'b0;
    for (int k = 0; k < N; k++) seq[k] = 0;
  endtask

  // Holds reset for two edges, checks the reset state, releases just after an edge.
  task automatic do_reset();
    i_rst_l   = 1'b0;
    i_af_flag = 1'b0;
    model_reset();
    drive_data();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_grant", o_grant, '0);
    check("rst_ack", o_ack, '0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_wr_dv", o_wr_dv, 1'b0);
    check("rst_wr_data", o_wr_data, '0);
    i_rst_l = 1'b1;
  endtask

  // Mid-cycle sample: compares every output against the model's prediction.
  task automatic sample();
    logic [N-1:0] eg;
    drive_data();
    @(negedge i_clk);
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    m_ack = (m_owner >= 0 && i_req[m_owner] && !i_af_flag) ? eg : '0;
    check("mdl_grant", o_grant, eg);
    check("mdl_ack", o_ack, m_ack);
    check("mdl_busy", o_busy, m_owner >= 0);
    check("mdl_wr_dv", o_wr_dv, m_dv);
    if (m_dv) check("mdl_wr_data", o_wr_data, m_data);
    check("ack_onehot0", $onehot0(o_ack), 1'b1);
    s_dv = o_wr_dv;
  endtask

  // Clock edge: advance model, FIFO occupancy and requester data, then settle inputs.
  task automatic advance();
    @(posedge i_clk);
    m_dv = (m_ack != '0);
    if (m_dv) m_data = i_data[m_owner*W +: W];
    if (fifo_mode) begin
      if (s_dv) begin
        check("fifo_not_full_on_write", fifo_cnt < DEPTH, 1'b1);
        fifo_cnt++;
      end
      if (pop_en && fifo_cnt > 0 && $urandom_range(0, 1) == 1) fifo_cnt--;
    end
    if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        if (m_owner < 0 && i_req[(m_last + i) % N]) begin
          m_owner = (m_last + i) % N;
          m_beats = 0;
        end
      end
    end else if (!i_af_flag) begin
      if (i_req[m_owner]) m_beats++;
      if (!i_req[m_owner] || m_beats == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    for (int k = 0; k < N; k++) if (m_ack[k]) seq[k]++;
    #1;
    if (fifo_mode) i_af_flag = (fifo_cnt >= DEPTH - AF_LVL);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  vec_t vecs [12];

  initial begin
    int ack_cyc [$];
    int wr_dat  [$];
    int owners  [$];
    int lens    [$];
    int acks, prev, cyc;

    i_req = '0;
    i_data = '0;
    do_reset();

    // --- Table: arbitration order, almost-full hold, request-drop exit ---
    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{4'b0110, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'h80};
    vecs[4]  = '{4'b0110, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{4'b0010, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'h81};
    vecs[6]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{4'b0011, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{4'b0001, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'h40};
    vecs[9]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    for (int i = 0; i < 12; i++) begin
      i_req     = vecs[i].req;
      i_af_flag = vecs[i].af;
      sample();
      check($sformatf("vec%0d_grant", i), o_grant, vecs[i].grant);
      check($sformatf("vec%0d_ack", i), o_ack, vecs[i].ack);
      check($sformatf("vec%0d_busy", i), o_busy, vecs[i].busy);
      check($sformatf("vec%0d_wr_dv", i), o_wr_dv, vecs[i].dv);
      if (vecs[i].dv) check($sformatf("vec%0d_wr_data", i), o_wr_data, vecs[i].data);
      advance();
    end

    // --- Single requester, 20 beats: full burst, one idle cycle, regrant ---
    do_reset();
    i_req = 4'b0001;
    cyc = 0;
    while (wr_dat.size() < 20 && cyc < 80) begin
      sample();
      if (o_ack[0]) ack_cyc.push_back(cyc);
      if (o_wr_dv) wr_dat.push_back(int'(o_wr_data));
      advance();
      cyc++;
    end
    check("solo_write_count", wr_dat.size(), 20);
    if (ack_cyc.size() >= 17) begin
      check("solo_first_ack_cycle", ack_cyc[0], 1);
      check("solo_16th_ack_cycle", ack_cyc[15], 16);
      check("solo_regrant_ack_cycle", ack_cyc[16], 18);
    end else check("solo_ack_count", ack_cyc.size(), 20);
    for (int i = 0; i < wr_dat.size(); i++) check($sformatf("solo_data%0d", i), wr_dat[i], i);

    // --- All four requesting: order 0,1,2,3,0 with 16-beat bursts ---
    do_reset();
    i_req = 4'b1111;
    acks = 0;
    prev = -1;
    cyc  = 0;
    while (acks < 5 * MB && cyc < 150) begin
      sample();
      if (o_ack != '0) begin
        acks++;
        if (idx_of(o_ack) != prev) begin
          owners.push_back(idx_of(o_ack));
          lens.push_back(0);
          prev = idx_of(o_ack);
        end
        lens[lens.size()-1]++;
      end
      advance();
      cyc++;
    end
    check("rr_burst_count", owners.size(), 5);
    for (int i = 0; i < owners.size() && i < 5; i++) begin
      check($sformatf("rr_owner%0d", i), owners[i], i % N);
      check($sformatf("rr_len%0d", i), lens[i], MB);
    end

    // --- Almost-full for 5 cycles mid-burst ---
    do_reset();
    i_req = 4'b0001;
    acks = 0;
    cyc  = 0;
    while (acks < 5 && cyc < 20) begin
      sample();
      if (o_ack[0]) acks++;
      advance();
      cyc++;
    end
    i_af_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("af_no_ack", o_ack, '0);
      check("af_grant_held", o_grant, 4'b0001);
      if (i > 0) check("af_no_wr_dv", o_wr_dv, 1'b0);
      advance();
    end
    i_af_flag = 1'b0;
    cyc = 0;
    sample();
    check("af_release_no_wr_dv", o_wr_dv, 1'b0);
    while (o_busy && cyc < 40) begin
      if (o_ack[0]) acks++;
      advance();
      sample();
      cyc++;
    end
    advance();
    check("af_burst_total", acks, MB);

    // --- Reset at beat 7 of requester 1's burst; requester 0 regains priority ---
    do_reset();
    i_req = 4'b0011;
    acks = 0;
    cyc  = 0;
    while (acks < 7 && cyc < 60) begin
      sample();
      if (o_ack[1]) acks++;
      if (acks < 7) advance();
      cyc++;
    end
    check("rst_mid_reached_beat7", acks, 7);
    #1 i_rst_l = 1'b0;
    #1;
    check("rst_mid_grant", o_grant, '0);
    check("rst_mid_ack", o_ack, '0);
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_wr_dv", o_wr_dv, 1'b0);
    check("rst_mid_wr_data", o_wr_data, '0);
    do_reset();
    step();
    sample();
    check("rst_mid_req0_first", o_grant, 4'b0001);
    advance();

    // --- FIFO with no reads: fills to the almost-full level and stops ---
    do_reset();
    fifo_mode = 1'b1;
    i_req = 4'b1111;
    repeat (150) step();
    check("fifo_fill_max", fifo_cnt <= DEPTH, 1'b1);
    check("fifo_fill_min", fifo_cnt >= DEPTH - AF_LVL, 1'b1);

    // --- Randomized traffic with random FIFO drain ---
    pop_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 11) == 0) i_req[k] = ~i_req[k];
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the data width of every requester and of the FIFO write port.
REQ-003 Parameter MAX_BURST, default 16, SHALL set the maximum beats accepted per grant (1..255).
REQ-004 i_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 i_rst_l  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_req  in  N_REQ  SHALL be the per-requester write request, level, held while data is pending.
REQ-007 i_data  in  N_REQ*WIDTH  SHALL carry requester k's beat in bits [k*WIDTH +: WIDTH].
REQ-008 o_ack  out  N_REQ  SHALL pulse one cycle per beat accepted from that requester.
REQ-009 o_grant  out  N_REQ  SHALL be the one-hot current burst owner; all zero when idle.
REQ-010 o_wr_dv  out  1  SHALL be the FIFO write strobe.
REQ-011 o_wr_data  out  WIDTH  SHALL be the FIFO write data.
REQ-012 i_af_flag  in  1  SHALL be the FIFO almost-full flag; integration sets the FIFO almost-full level to 2 or more.
REQ-013 o_busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-015 IDLE: if any i_req bit is high, the block SHALL pick the first requester at or after index (last_owner+1) mod N_REQ, scanning upward with wrap-around, and enter BURST with o_grant one-hot for that requester.
REQ-016 IDLE with no request SHALL stay IDLE with o_grant=0.
REQ-017 The IDLE-to-BURST transition SHALL take one cycle; o_ack SHALL NOT assert in IDLE.
REQ-018 BURST: o_ack[g] SHALL equal o_grant[g] & i_req[g] & ~i_af_flag, combinationally, in the same cycle.
REQ-019 On each acked cycle, the block SHALL register i_data slice g into o_wr_data and set o_wr_dv=1 on the next cycle; otherwise o_wr_dv=0 next cycle (write latency: exactly 1 cycle from ack).
REQ-020 An 8-bit beat counter SHALL clear on BURST entry and increment on each ack.
REQ-021 BURST SHALL return to IDLE, recording last_owner=g, when either (a) the ack makes the count equal MAX_BURST, or (b) i_req[g]=0 in BURST.
REQ-022 While i_af_flag=1, BURST SHALL hold: grant kept, no ack, counter frozen, no timeout.
REQ-023 A requester dropping and re-raising i_req while not granted SHALL NOT affect arbitration order.
REQ-024 Non-granted requesters SHALL never see o_ack, and o_ack SHALL be one-hot or zero.
REQ-025 Round-robin SHALL guarantee that a continuously requesting requester is granted within N_REQ-1 other bursts.

Reset
REQ-026 While i_rst_l=0: state=IDLE, o_grant=0, o_ack=0, o_wr_dv=0, o_wr_data=0, o_busy=0, beat counter=0, last_owner=N_REQ-1 (so requester 0 wins first).
REQ-027 Reset asserted mid-burst SHALL abort immediately with no further o_wr_dv; a beat acked in the reset cycle is lost by design.

Structure
REQ-028 FSM state encodings and the default-MAX_BURST constant SHALL live in a shared package used by the arbiter and its bench.
REQ-029 Round-robin selection SHALL be a sub-module, rr_pick (inputs: request vector, last_owner; outputs: one-hot pick, valid); everything else stays in fifo_wr_arbiter.
REQ-030 The block SHALL connect directly to the FIFO write port (o_wr_dv to i_wr_dv, o_wr_data to i_wr_data, FIFO o_af_flag to i_af_flag) with no glue logic.

Verification
REQ-031 Reset release, then i_req=4'b0001 holding data 0x00..0x13 for 20 beats -> grant[0] on cycle 1, 16 acks, o_wr_dv sequence 0x00..0x0F, IDLE one cycle, regrant req0, 4 more beats.
REQ-032 i_req=4'b1111 held constantly -> grant order 0,1,2,3,0; each burst has 16 beats; o_ack is never more than one-hot.
REQ-033 req2 grants, sends 3 beats, then drops i_req[2] -> BURST exits after 3 writes; next grant goes to the next requester above 2.
REQ-034 i_af_flag=1 for 5 cycles mid-burst -> no ack and no o_wr_dv for those cycles; grant and beat count are preserved; the burst resumes and completes at 16.
REQ-035 Assert i_rst_l=0 at beat 7 of a burst -> all outputs 0 asynchronously; after release, requester 0 has priority again.
REQ-036 Connected to the FIFO with DEPTH=32 and af_level=2, with four requesters and no reads -> the FIFO fills to at most DEPTH with no "Writing Full FIFO" error, and all written data matches in order per burst.
